// File: rtl/ral_reg_bank.sv
// Multi-channel RAL register bank: CTRL/STAT(W1C)/CMD plus NCH DIN/DOUT pairs behind valid/ready request/response channels.
// Optional DIN-write auto-commit is built when RAL_REG_BANK_AUTO_COMMIT_EN is defined.
module ral_reg_bank #(
   parameter int DW  = 8,
   parameter int NCH = 2,
   parameter int AW  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [AW-1:0]     req_addr,
   input  logic [DW-1:0]     req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_rdata,
   output logic              rsp_err,
   output logic [NCH*DW-1:0] dout_bus,
   output logic              irq
);

   localparam logic [AW-1:0] CH_BASE = AW'(4);
`ifdef RAL_REG_BANK_AUTO_COMMIT_EN
   localparam logic [DW-1:0] CTRL_MASK = '1;
`else
   // Without auto-commit the auto bit is read-only zero.
   localparam logic [DW-1:0] CTRL_MASK = ~(DW'(4));
`endif

   logic [DW-1:0]     ctrl_reg;
   logic [1:0]        stat_reg;
   logic [1:0]        stat_next;
   logic [1:0]        stat_w1c;
   logic [1:0]        stat_set;
   logic              rsp_valid_reg;
   logic              rsp_err_reg;
   logic [DW-1:0]     rsp_rdata_reg;
   logic              irq_reg;
   logic [DW-1:0]     rd_data;

   logic              accept;
   logic              wr_acc;
   logic              is_ctrl;
   logic              is_stat;
   logic              is_cmd;
   logic              chan_hit;
   logic              err_ev;
   logic              done_ev;
   logic [AW-1:0]     off;
   logic [AW-1:0]     ch_num;
   logic [NCH-1:0]    din_sel;
   logic [NCH-1:0]    dout_sel;
   logic [NCH-1:0]    commit_vec;
   logic [NCH-1:0]    auto_vec;
   logic [NCH*DW-1:0] din_flat;
   logic [NCH*DW-1:0] dout_flat;

   assign req_ready = !rsp_valid_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;
   assign irq       = irq_reg;
   assign dout_bus  = dout_flat;

   assign accept   = req_valid && !rsp_valid_reg;
   assign wr_acc   = accept && req_wr;
   assign is_ctrl  = (req_addr == AW'(0));
   assign is_stat  = (req_addr == AW'(1));
   assign is_cmd   = (req_addr == AW'(2));
   assign off      = req_addr - CH_BASE;
   assign ch_num   = off >> 1;
   assign chan_hit = (req_addr >= CH_BASE) && (ch_num < AW'(NCH));

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [DW-1:0] din_reg;
         logic [DW-1:0] dout_reg;

         assign din_sel[gi]  = chan_hit && (ch_num == AW'(gi)) && !off[0];
         assign dout_sel[gi] = chan_hit && (ch_num == AW'(gi)) && off[0];

         if (gi < DW) begin : g_cmd
            assign commit_vec[gi] = wr_acc && is_cmd && ctrl_reg[0] && req_wdata[gi];
         end else begin : g_nocmd
            assign commit_vec[gi] = 1'b0;
         end

`ifdef RAL_REG_BANK_AUTO_COMMIT_EN
         // Fires the cycle after the DIN write, when din_reg already holds the new value.
         logic pend_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               pend_reg <= 1'b0;
            end else begin
               pend_reg <= wr_acc && din_sel[gi] && ctrl_reg[2] && ctrl_reg[0];
            end
         end
         assign auto_vec[gi] = pend_reg;
`else
         assign auto_vec[gi] = 1'b0;
`endif

         always_ff @(posedge clk) begin
            if (rst) begin
               din_reg  <= '0;
               dout_reg <= '0;
            end else begin
               if (wr_acc && din_sel[gi]) begin
                  din_reg <= req_wdata;
               end
               if (commit_vec[gi] || auto_vec[gi]) begin
                  dout_reg <= din_reg;
               end
            end
         end

         assign din_flat[gi*DW +: DW]  = din_reg;
         assign dout_flat[gi*DW +: DW] = dout_reg;
      end
   endgenerate

   assign err_ev  = accept && ((req_wr && is_cmd && !ctrl_reg[0]) ||
                               (req_wr && (|dout_sel)) ||
                               !(is_ctrl || is_stat || is_cmd || chan_hit));
   assign done_ev = (|commit_vec) || (|auto_vec);

   // Hardware set is OR-ed after the W1C clear so set wins on a collision.
   assign stat_w1c  = (wr_acc && is_stat) ? req_wdata[1:0] : 2'b00;
   assign stat_set  = {err_ev, done_ev};
   assign stat_next = (stat_reg & ~stat_w1c) | stat_set;

   always_comb begin
      rd_data = '0;
      if (is_ctrl) begin
         rd_data = ctrl_reg;
      end else if (is_stat) begin
         rd_data = {{(DW-2){1'b0}}, stat_reg};
      end
      for (int c = 0; c < NCH; c++) begin
         if (din_sel[c]) begin
            rd_data = din_flat[c*DW +: DW];
         end
         if (dout_sel[c]) begin
            rd_data = dout_flat[c*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_reg      <= '0;
         stat_reg      <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
         irq_reg       <= 1'b0;
      end else begin
         stat_reg <= stat_next;
         irq_reg  <= ctrl_reg[1] & (|stat_reg);
         if (wr_acc && is_ctrl) begin
            ctrl_reg <= req_wdata & CTRL_MASK;
         end
         if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_rdata_reg <= req_wr ? '0 : rd_data;
            rsp_err_reg   <= err_ev;
         end else if (rsp_valid_reg && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
         end
      end
   end

endmodule
